uart_tx_stream: RTL and testbench

//  Buffered, parametrised UART transmitter: next generation of the single-byte transmitter.

---
 rtl/uart_tx_stream.sv | 202 ++++++++++++++++++++
 tb/tb_uart_tx_stream.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_stream.sv
// Buffered UART transmitter: a valid/ready stream feeds a small FIFO, and
// frames are serialised back-to-back. Data bits (5..DATA_WIDTH), parity and
// stop bits are selectable at runtime and latched per frame.
module uart_tx_stream #(
    parameter int CLOCK_DIVIDER_WIDTH = 16,
    parameter int DATA_WIDTH          = 9,
    parameter int FIFO_DEPTH          = 8,
    parameter int POST_RESET_BITS     = 12
) (
    input  logic                              clock_i,
    input  logic                              reset_i,
    input  logic [CLOCK_DIVIDER_WIDTH-1:0]    clock_divider_i,
    input  logic [3:0]                        data_bits_i,
    input  logic                              parity_bit_i,
    input  logic                              parity_even_i,
    input  logic                              two_stop_bits_i,
    input  logic                              valid_i,
    input  logic [DATA_WIDTH-1:0]             data_i,
    output logic                              ready_o,
    output logic                              serial_o,
    output logic                              busy_o,
    output logic                              tx_done_o,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_count_o
);

    localparam int CDW  = CLOCK_DIVIDER_WIDTH;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam int GW   = $clog2(POST_RESET_BITS + 1);

    localparam logic [CDW-1:0]  ONE        = CDW'(1);
    localparam logic [3:0]      MIN_BITS   = 4'd5;
    localparam logic [3:0]      MAX_BITS   = 4'(DATA_WIDTH);
    localparam logic [GW-1:0]   GUARD_LAST = GW'(POST_RESET_BITS - 1);
    localparam logic [CNTW-1:0] FULL_COUNT = CNTW'(FIFO_DEPTH);

    typedef enum logic [1:0] {GUARD, IDLE, SEND} state_t;

    state_t          state, state_next;
    logic [CDW-1:0]  timer, timer_next;
    logic [CDW-1:0]  period;
    logic [CDW-1:0]  live_period;
    logic [3:0]      bit_idx, bit_idx_next;
    logic [3:0]      frame_len;
    logic [3:0]      n_bits;
    logic [GW-1:0]   guard_bits, guard_bits_next;
    logic [15:0]     frame_bits;
    logic            serial_next;
    logic            load;
    logic            tx_done;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CNTW-1:0]       count;
    logic                  push;

    // Clamp the requested data-bit count into the supported range.
    function automatic logic [3:0] clamp_bits(input logic [3:0] b);
        if (b < MIN_BITS) return MIN_BITS;
        if (b > MAX_BITS) return MAX_BITS;
        return b;
    endfunction

    // Whole frame as a bit vector, index 0 sent first; unused upper bits and
    // stop bits are 1, so the line reads idle past the end of the frame.
    function automatic logic [15:0] build_frame(input logic [DATA_WIDTH-1:0] d,
                                                input logic [3:0] n,
                                                input logic par_en,
                                                input logic even);
        logic [15:0] f;
        logic        x;
        f    = '1;
        f[0] = 1'b0;
        x    = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (4'(i) < n) begin
                f[i + 1] = d[i];
                x        = x ^ d[i];
            end
        end
        if (par_en) f[n + 4'd1] = even ? x : ~x;
        return f;
    endfunction

    assign live_period  = (clock_divider_i == '0) ? ONE : clock_divider_i;
    assign n_bits       = clamp_bits(data_bits_i);
    assign ready_o      = (state != GUARD) && (count < FULL_COUNT);
    assign push         = valid_i & ready_o;
    assign fifo_count_o = count;
    assign tx_done_o    = tx_done;
    assign busy_o       = reset_i | (state != IDLE) | (count != '0);

    // Next-state logic: guard timing, frame start/pop and bit sequencing.
    always_comb begin
        state_next      = state;
        timer_next      = timer;
        bit_idx_next    = bit_idx;
        guard_bits_next = guard_bits;
        serial_next     = serial_o;
        load            = 1'b0;
        tx_done         = 1'b0;
        unique case (state)
            GUARD: begin
                serial_next = 1'b1;
                // >= keeps the guard bounded if the divider shrinks mid-period.
                if (timer >= live_period - ONE) begin
                    timer_next = '0;
                    if (guard_bits == GUARD_LAST) begin
                        guard_bits_next = '0;
                        state_next      = IDLE;
                    end else begin
                        guard_bits_next = guard_bits + 1'b1;
                    end
                end else begin
                    timer_next = timer + ONE;
                end
            end
            IDLE: begin
                serial_next = 1'b1;
                if (count != '0) begin
                    load         = 1'b1;
                    serial_next  = 1'b0;
                    timer_next   = '0;
                    bit_idx_next = '0;
                    state_next   = SEND;
                end
            end
            SEND: begin
                if (timer == period - ONE) begin
                    timer_next = '0;
                    if (bit_idx == frame_len - 4'd1) begin
                        tx_done = 1'b1;
                        // Chain straight into the next start bit when data is waiting.
                        if (count != '0) begin
                            load         = 1'b1;
                            serial_next  = 1'b0;
                            bit_idx_next = '0;
                        end else begin
                            serial_next = 1'b1;
                            state_next  = IDLE;
                        end
                    end else begin
                        bit_idx_next = bit_idx + 4'd1;
                        serial_next  = frame_bits[bit_idx + 4'd1];
                    end
                end else begin
                    timer_next = timer + ONE;
                end
            end
            default: state_next = GUARD;
        endcase
    end

    // Control state register; reset abandons any frame and re-enters the guard.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state      <= GUARD;
            timer      <= '0;
            bit_idx    <= '0;
            guard_bits <= '0;
            serial_o   <= 1'b1;
        end else begin
            state      <= state_next;
            timer      <= timer_next;
            bit_idx    <= bit_idx_next;
            guard_bits <= guard_bits_next;
            serial_o   <= serial_next;
        end
    end

    // Per-frame configuration snapshot taken when the head word is popped.
    always_ff @(posedge clock_i) begin
        if (load) begin
            frame_bits <= build_frame(mem[rd_ptr], n_bits, parity_bit_i, parity_even_i);
            frame_len  <= 4'd2 + n_bits + {3'b000, parity_bit_i} + {3'b000, two_stop_bits_i};
            period     <= live_period;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clock_i) begin
        if (push) mem[wr_ptr] <= data_i;
    end

    // FIFO pointers and occupancy; power-of-two depth lets pointers wrap freely.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (load) rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, load})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Testbench for uart_tx_stream: stimulus pushes expected frames into a
// scoreboard queue; an independent line monitor decodes serial_o and compares.
module tb_uart_tx_stream;

    localparam int CDW   = 16;
    localparam int DW    = 9;
    localparam int DEPTH = 8;
    localparam int PRB   = 12;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [CDW-1:0] div = 16'd4;
    logic [3:0]     nbits = 4'd8;
    logic           par_en = 1'b0;
    logic           par_even = 1'b0;
    logic           two_stop = 1'b0;
    logic           valid = 1'b0;
    logic [DW-1:0]  data = '0;
    logic           ready;
    logic           serial;
    logic           busy;
    logic           tx_done;
    logic [3:0]     fcount;

    uart_tx_stream #(
        .CLOCK_DIVIDER_WIDTH(CDW),
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH),
        .POST_RESET_BITS(PRB)
    ) dut (
        .clock_i(clk),
        .reset_i(rst),
        .clock_divider_i(div),
        .data_bits_i(nbits),
        .parity_bit_i(par_en),
        .parity_even_i(par_even),
        .two_stop_bits_i(two_stop),
        .valid_i(valid),
        .data_i(data),
        .ready_o(ready),
        .serial_o(serial),
        .busy_o(busy),
        .tx_done_o(tx_done),
        .fifo_count_o(fcount)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] bits;
        int          len;
        int          p;
        logic [DW-1:0] word;
    } frame_t;

    frame_t exp_q[$];
    int     start_q[$];
    int     total = 0;
    int     bad = 0;
    int     frames_started = 0;
    int     frames_done = 0;
    int     last_start = 0;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic check(input bit ok, input string name, input int act, input int req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference frame built straight from the framing rules.
    function automatic frame_t model(input logic [DW-1:0] w, input int nb, input bit pe,
                                     input bit ev, input bit two, input int dv);
        frame_t f;
        int n;
        int k;
        bit x;
        n = (nb < 5) ? 5 : ((nb > DW) ? DW : nb);
        f.p = (dv == 0) ? 1 : dv;
        f.word = w;
        f.bits = '0;
        k = 0;
        f.bits[k] = 1'b0; k++;
        x = 1'b0;
        for (int i = 0; i < n; i++) begin
            f.bits[k] = w[i];
            x = x ^ w[i];
            k++;
        end
        if (pe) begin
            f.bits[k] = ev ? x : ~x;
            k++;
        end
        f.bits[k] = 1'b1; k++;
        if (two) begin
            f.bits[k] = 1'b1; k++;
        end
        f.len = k;
        return f;
    endfunction

    // Line monitor: decodes each frame from its falling start edge.
    initial begin : monitor
        frame_t e;
        bit abort;
        int badbit;
        int dn_err;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0 || serial !== 1'b0) continue;
            frames_started++;
            last_start = cyc;
            start_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_frame: start at cycle %0d, none expected", cyc);
                while (serial === 1'b0) @(negedge clk);
                continue;
            end
            e = exp_q.pop_front();
            abort = 0;
            badbit = -1;
            dn_err = 0;
            for (int b = 0; b < e.len && !abort; b++) begin
                for (int c = 0; c < e.p && !abort; c++) begin
                    if (b != 0 || c != 0) @(negedge clk);
                    if (rst) abort = 1;
                    else begin
                        if (serial !== e.bits[b] && badbit < 0) badbit = b;
                        if (tx_done !== ((b == e.len - 1) && (c == e.p - 1))) dn_err++;
                    end
                end
            end
            if (!abort) begin
                if (badbit >= 0)
                    $display("word 0x%0h: first wrong bit at frame position %0d", e.word, badbit);
                check(badbit < 0, "frame_bits_first_bad_pos", badbit, -1);
                check(dn_err == 0, "tx_done_wrong_cycles", dn_err, 0);
                frames_done++;
            end
        end
    end

    task automatic push(input logic [DW-1:0] w, output int edge_n);
        bit rdy;
        edge_n = -1;
        valid = 1'b1;
        data = w;
        for (int budget = 0; budget < 400; budget++) begin
            @(negedge clk);
            rdy = ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                edge_n = cyc;
                break;
            end
        end
        valid = 1'b0;
        if (edge_n < 0) begin
            total++;
            bad++;
            $display("FAIL push_timeout: word 0x%0h never accepted", w);
        end else begin
            exp_q.push_back(model(w, int'(nbits), par_en, par_even, two_stop, int'(div)));
        end
    endtask

    task automatic wait_start(input int fs0);
        int n;
        n = 0;
        while (frames_started == fs0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(frames_started != fs0, "frame_start_seen", frames_started, fs0 + 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || exp_q.size() != 0) && n < 3000);
        @(negedge clk);
        check(busy == 1'b0, "busy_when_idle", busy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int e;
        int g_ok;
        int fs0;
        int fs1;
        int base;
        int flen;
        int n;

        // Reset and guard period with divider 4.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        g_ok = 0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check(serial == 1'b1, "reset_serial", serial, 1);
                check(ready == 1'b0, "reset_ready", ready, 0);
                check(tx_done == 1'b0, "reset_tx_done", tx_done, 0);
                check(fcount == 4'd0, "reset_count", fcount, 0);
                check(busy == 1'b1, "reset_busy", busy, 1);
            end
            if (serial == 1'b1 && ready == 1'b0) g_ok++;
        end
        check(g_ok == 48, "guard_cycles", g_ok, 48);
        @(negedge clk);
        check(ready == 1'b1, "ready_after_guard", ready, 1);
        check(busy == 1'b0, "idle_after_guard", busy, 0);
        @(posedge clk);
        #1;

        // 8N1 frame of 0xA5 and start-bit latency.
        div = 16'd4; nbits = 4'd8; par_en = 0; two_stop = 0;
        fs0 = frames_started;
        push(9'h0A5, e);
        wait_start(fs0);
        check(last_start == e + 1, "start_latency", last_start, e + 1);
        wait_idle();

        // 7E2 then 7O2 frames of 0x55.
        nbits = 4'd7; par_en = 1; par_even = 1; two_stop = 1;
        push(9'h055, e);
        wait_idle();
        par_even = 0;
        push(9'h055, e);
        wait_idle();

        // Fill the FIFO past full; frames must abut and stay in order.
        div = 16'd2; nbits = 4'd8; par_en = 1'($urandom); par_even = 1'($urandom); two_stop = 0;
        base = start_q.size();
        for (int i = 0; i < DEPTH + 2; i++) begin
            push(9'($urandom), e);
            if (i == DEPTH) begin
                @(negedge clk);
                check(fcount == 4'(DEPTH), "count_at_full", fcount, DEPTH);
                check(ready == 1'b0, "ready_at_full", ready, 0);
            end
        end
        wait_idle();
        flen = model('0, 8, par_en, par_even, 0, 2).len * 2;
        check(start_q.size() - base == DEPTH + 2, "burst_frames", start_q.size() - base, DEPTH + 2);
        for (int j = base + 1; j < start_q.size(); j++)
            check(start_q[j] - start_q[j-1] == flen, "frame_spacing", start_q[j] - start_q[j-1], flen);

        // Reset during data bit 3: queued words are dropped, guard repeats.
        div = 16'd4; nbits = 4'd8; par_en = 0; two_stop = 0;
        fs0 = frames_started;
        push(9'h03C, e);
        push(9'h0C3, e);
        push(9'h1FF, e);
        wait_start(fs0);
        repeat (16) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        fs1 = frames_started;
        @(negedge clk);
        check(serial == 1'b1, "serial_after_midframe_reset", serial, 1);
        check(fcount == 4'd0, "count_after_midframe_reset", fcount, 0);
        n = 0;
        while (ready == 1'b0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check(n == 48, "guard_after_midframe_reset", n, 48);
        repeat (100) @(negedge clk);
        check(frames_started == fs1, "no_frame_after_reset", frames_started, fs1);
        @(posedge clk);
        #1;

        // Divider 0 -> 1 clock per bit; data bits clamped at both ends.
        div = 16'd0; nbits = 4'd2; par_en = 1; par_even = 1'($urandom); two_stop = 1'($urandom);
        push(9'($urandom), e);
        wait_idle();
        nbits = 4'd15; par_en = 1'($urandom);
        push(9'($urandom), e);
        wait_idle();

        // Random configurations, scrambled once each frame is underway.
        for (int k = 0; k < 6; k++) begin
            div = 16'($urandom_range(0, 5));
            nbits = 4'($urandom_range(0, 15));
            par_en = 1'($urandom); par_even = 1'($urandom); two_stop = 1'($urandom);
            fs0 = frames_started;
            push(9'($urandom), e);
            wait_start(fs0);
            div = 16'($urandom_range(0, 7));
            nbits = 4'($urandom_range(0, 15));
            par_en = 1'($urandom); par_even = 1'($urandom); two_stop = 1'($urandom);
            wait_idle();
        end

        check(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
